// File: rtl/dds_phase_gen.sv
// DDS phase accumulator and waveform shaper: consumes Ready/Enable sampling strobes
// and emits one registered 8-bit sample per strobe, two clocks after the strobe.
module dds_phase_gen #(
  parameter int ACC_W  = 24,
  parameter int DATA_W = 8
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              Ready,
  input  logic              Enable,
  input  logic [ACC_W-1:0]  FreqWord,
  input  logic [1:0]        WaveSel,
  output logic [DATA_W-1:0] SampData,
  output logic              SampValid,
  output logic              Wrap
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] WAVE_SAW  = 2'd0;
  localparam logic [1:0] WAVE_RAMP = 2'd1;
  localparam logic [1:0] WAVE_SQR  = 2'd2;

  state_t             state;
  state_t             stateNext;
  logic               accEn;
  logic               reload;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   inc;
  logic [1:0]         wave;
  logic [ACC_W-1:0]   phase_p1;
  logic [1:0]         wave_p1;
  logic               carry_p1;
  logic               vld_p1;

  function automatic logic [DATA_W-1:0] shapeSample(input logic [ACC_W-1:0] ph,
                                                    input logic [1:0]       w);
    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] t;
    logic              m;
    p = ph[ACC_W-1 -: DATA_W];
    t = ph[ACC_W-2 -: DATA_W];
    m = ph[ACC_W-1];
    case (w)
      WAVE_SAW:  shapeSample = p;
      WAVE_RAMP: shapeSample = ~p;
      WAVE_SQR:  shapeSample = m ? '0 : '1;
      default:   shapeSample = m ? ~t : t;
    endcase
  endfunction

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    accEn     = 1'b0;
    case (state)
      IDLE: if (Ready) stateNext = RUN;
      RUN: begin
        if (!Ready) stateNext = IDLE;
        else        accEn = Enable;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign sum = {1'b0, phase_p1} + {1'b0, inc};
  // Tuning word and wave only change at a phase boundary so a retune never glitches mid-period.
  assign reload = ((state == IDLE) && Ready) || (accEn && sum[ACC_W]);

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      inc  <= '0;
      wave <= '0;
    end else if (reload) begin
      inc  <= FreqWord;
      wave <= WaveSel;
    end
  end

  // ---- stage 1: accumulate ----
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      phase_p1 <= '0;
      wave_p1  <= '0;
      carry_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else if ((state != RUN) || !Ready) begin
      phase_p1 <= '0;
      carry_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (Enable) begin
      phase_p1 <= sum[ACC_W-1:0];
      carry_p1 <= sum[ACC_W];
      wave_p1  <= wave;
      vld_p1   <= 1'b1;
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  // ---- stage 2: shape; a Ready drop kills a strobe still in flight ----
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      SampData  <= '0;
      SampValid <= 1'b0;
      Wrap      <= 1'b0;
    end else if (vld_p1 && (state == RUN) && Ready) begin
      SampData  <= shapeSample(phase_p1, wave_p1);
      SampValid <= 1'b1;
      Wrap      <= carry_p1;
    end else begin
      SampValid <= 1'b0;
      Wrap      <= 1'b0;
    end
  end

endmodule
